// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU command sequencer: command bytes,
// FSM state encoding, error codes and the payload-destination select.
package uart_alu_pkg;

  localparam logic [7:0] CMD_A  = 8'hA1;
  localparam logic [7:0] CMD_B  = 8'hB2;
  localparam logic [7:0] CMD_OP = 8'hC3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_DATA = 3'd1;
  localparam logic [2:0] ST_EXEC      = 3'd2;
  localparam logic [2:0] ST_TX_START  = 3'd3;
  localparam logic [2:0] ST_TX_WAIT   = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [1:0] {
    SEL_A  = 2'd0,
    SEL_B  = 2'd1,
    SEL_OP = 2'd2
  } cmd_sel_e;

endpackage

// File: rtl/uart_alu_ctrl_frame_timer.sv
// Inter-byte timer: clear/enable up-counter that stops at TIMEOUT_CYC-1 and
// flags that value as terminal count.
// Ports:
//   clk, i_rst_n   clock, async active-low reset
//   i_clr          synchronous clear to 0 (wins over i_en)
//   i_en           count one per cycle
//   o_tc           count has reached TIMEOUT_CYC-1
module frame_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q, count_d;

  assign o_tc = (count_q == TC_VAL);

  // Holding at the terminal value keeps the flag asserted instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (i_clr)
      count_d = '0;
    else if (i_en && !o_tc)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Command sequencer between UART RX/TX and an external ALU. Parses
// (command, payload) byte pairs, loads operand A, operand B or the opcode,
// and after an opcode load returns the ALU result through the TX handshake.
// Ports:
//   clk, i_rst_n             clock, async active-low reset
//   i_rx_data, i_rx_done     received byte and its 1-cycle strobe
//   o_alu_data_a/_b, o_alu_op registered ALU operands and opcode
//   i_alu_result             combinational ALU result
//   o_tx_data, o_tx_start    byte to send and 1-cycle start pulse
//   i_tx_done                1-cycle TX completion pulse
//   o_busy                   FSM not idle
//   o_err, o_err_code        1-cycle error pulse and sticky error code
//
// state     | meaning
// IDLE      | waiting for a command byte
// WAIT_DATA | command latched, waiting for payload, timer running
// EXEC      | opcode just loaded, ALU settling
// TX_START  | result captured, pulsing o_tx_start
// TX_WAIT   | waiting for i_tx_done
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_err,
  output logic [1:0]         o_err_code
);

  logic [2:0]         state_q, state_d;
  cmd_sel_e           sel_q, sel_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               timer_tc;

  frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame_timer (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state_q == ST_IDLE),
    .i_en    (state_q == ST_WAIT_DATA),
    .o_tc    (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == NB_DATA'(CMD_A)) begin
            sel_d   = SEL_A;
            state_d = ST_WAIT_DATA;
          end else if (i_rx_data == NB_DATA'(CMD_B)) begin
            sel_d   = SEL_B;
            state_d = ST_WAIT_DATA;
          end else if (i_rx_data == NB_DATA'(CMD_OP)) begin
            sel_d   = SEL_OP;
            state_d = ST_WAIT_DATA;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_CMD;
          end
        end
      end
      ST_WAIT_DATA: begin
        // A payload arriving on the terminal-count cycle is still accepted.
        if (i_rx_done) begin
          case (sel_q)
            SEL_A: begin
              a_d     = i_rx_data;
              state_d = ST_IDLE;
            end
            SEL_B: begin
              b_d     = i_rx_data;
              state_d = ST_IDLE;
            end
            default: begin
              op_d    = i_rx_data[NB_OP-1:0];
              state_d = ST_EXEC;
            end
          endcase
        end else if (timer_tc) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end
      end
      ST_EXEC: begin
        tx_data_d = i_alu_result;
        state_d   = ST_TX_START;
      end
      ST_TX_START: begin
        state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (i_tx_done)
          state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bytes arriving while a result is in flight are dropped and reported.
    if (i_rx_done && (state_q == ST_EXEC || state_q == ST_TX_START ||
                      state_q == ST_TX_WAIT)) begin
      err_d      = 1'b1;
      err_code_d = ERR_OVERRUN;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Decoded straight from the state flop so reset removes them immediately.
  assign o_tx_start   = (state_q == ST_TX_START);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_alu_data_a = a_q;
  assign o_alu_data_b = b_q;
  assign o_alu_op     = op_q;
  assign o_tx_data    = tx_data_q;
  assign o_err        = err_q;
  assign o_err_code   = err_code_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       tx_start, tx_done, busy, err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: 0x20 ADD, 0x22 SUB.
  always_comb begin
    alu_result = 8'h00;
    if (alu_op == 6'h20)      alu_result = alu_a + alu_b;
    else if (alu_op == 6'h22) alu_result = alu_a - alu_b;
  end

  uart_alu_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .o_alu_data_a (alu_a),
    .o_alu_data_b (alu_b),
    .o_alu_op     (alu_op),
    .i_alu_result (alu_result),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_done    (tx_done),
    .o_busy       (busy),
    .o_err        (err),
    .o_err_code   (err_code)
  );

  initial tx_done = 1'b0;

  // Returns at the negedge following the sampling posedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, err, err_code} !== '0) begin
      errors++;
      $display("FAIL reset_in got a=%h b=%h op=%h tx=%h st=%b busy=%b err=%b code=%b exp all 0",
               alu_a, alu_b, alu_op, tx_data, tx_start, busy, err, err_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, err, err_code} !== '0) begin
      errors++;
      $display("FAIL reset_after got a=%h b=%h op=%h busy=%b err=%b exp all 0",
               alu_a, alu_b, alu_op, busy, err);
    end
  endtask

  task automatic test_add();
    send_byte(8'hA1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_wait got %b exp 1", busy); end
    send_byte(8'h05);
    send_byte(8'hB2);
    send_byte(8'h03);
    send_byte(8'hC3);
    send_byte(8'h20);
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
      errors++; $display("FAIL add_regs got %h %h %h exp 05 03 20", alu_a, alu_b, alu_op);
    end
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL add_exec_start got %b exp 0", tx_start); end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
      errors++; $display("FAIL add_tx got start=%b data=%h exp 1 08", tx_start, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'h08) begin
      errors++; $display("FAIL add_txwait got start=%b busy=%b data=%h exp 0 1 08", tx_start, busy, tx_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL add_hold got busy=%b exp 1", busy); end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL add_done got busy=%b err=%b exp 0 0", busy, err);
    end
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h7F);
    checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_cmd got err=%b code=%b busy=%b exp 1 01 0", err, err_code, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || err_code !== 2'b01) begin
      errors++; $display("FAIL bad_cmd_pulse got err=%b code=%b exp 0 01", err, err_code);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
      errors++; $display("FAIL bad_cmd_regs got %h %h %h exp 05 03 20", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_overrun();
    send_byte(8'hC3);
    send_byte(8'h22);
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h02) begin
      errors++; $display("FAIL sub_tx got start=%b data=%h exp 1 02", tx_start, tx_data);
    end
    @(negedge clk);
    send_byte(8'h55);
    checks++;
    if (err !== 1'b1 || err_code !== 2'b11 || busy !== 1'b1) begin
      errors++; $display("FAIL overrun got err=%b code=%b busy=%b exp 1 11 1", err, err_code, busy);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data} !== {8'h05, 8'h03, 6'h22, 8'h02}) begin
      errors++; $display("FAIL overrun_regs got %h %h %h %h exp 05 03 22 02", alu_a, alu_b, alu_op, tx_data);
    end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL overrun_done got busy=%b exp 0", busy); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    send_byte(8'hA1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL timeout_cycle got %0d exp 16", n); end
    checks++;
    if (err_code !== 2'b10 || busy !== 1'b0 || alu_a !== 8'h05) begin
      errors++; $display("FAIL timeout_state got code=%b busy=%b a=%h exp 10 0 05", err_code, busy, alu_a);
    end
    send_byte(8'hA1);
    send_byte(8'h09);
    checks++;
    if (alu_a !== 8'h09 || err !== 1'b0) begin
      errors++; $display("FAIL timeout_reload got a=%h err=%b exp 09 0", alu_a, err);
    end
  endtask

  task automatic test_timeout_edge();
    send_byte(8'hA1);
    repeat (14) @(negedge clk);
    send_byte(8'h33);
    checks++;
    if (alu_a !== 8'h33 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL tc_edge got a=%h err=%b busy=%b exp 33 0 0", alu_a, err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL tc_edge_late got err=%b exp 0", err); end
  endtask

  task automatic test_async_reset();
    send_byte(8'hC3);
    send_byte(8'h20);
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h36) begin errors++; $display("FAIL rst_pre_tx got %h exp 36", tx_data); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, err, err_code} !== '0) begin
      errors++; $display("FAIL async_rst got a=%h b=%h op=%h tx=%h busy=%b code=%b exp all 0",
                         alu_a, alu_b, alu_op, tx_data, busy, err_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hA1);
    send_byte(8'h07);
    send_byte(8'hB2);
    send_byte(8'h01);
    send_byte(8'hC3);
    send_byte(8'h22);
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h06) begin
      errors++; $display("FAIL rst_next_frame got start=%b data=%h exp 1 06", tx_start, tx_data);
    end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_next_done got busy=%b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_bad_cmd();
    test_overrun();
    test_timeout();
    test_timeout_edge();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
